eval_arbiter: RTL and testbench
===============================

Name: eval_arbiter

Overview:
- Round-robin scheduler that shares one eval datapath (8-bit ROM-lookup/invert/add kernel, one-cycle registered latency) between NUM_REQ requesters.
- Accepts operand pairs over valid/ready, drives the datapath operand and kernel-enable inputs, tracks the in-flight operation, and returns tagged results through a 2-entry response FIFO with backpressure.
- Sits directly in front of the eval datapath instance. Both share clk/rst.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ID_W, 2, width of requester tag; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester operation request
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a  input  NUM_REQ*8  packed operand A; slice i = [8*i+7:8*i]; A[3:0] is the ROM address
- req_b  input  NUM_REQ*8  packed operand B; datapath inverts it
- req_kernel  input  NUM_REQ  per-requester kernel-enable (1 = include ROM term)
- dp_data_in1  output  8  to datapath data_in1
- dp_data_in2  output  8  to datapath data_in2
- dp_kernel_enable  output  1  to datapath kernel_enable
- dp_clk_en  output  1  datapath clock-enable (see Optional Feature)
- dp_result  input  8  from datapath result, valid one cycle after issue
- rsp_valid  output  1  response FIFO non-empty
- rsp_ready  input  1  downstream accept
- rsp_id  output  ID_W  requester index of head response
- rsp_data  output  8  head response result
- busy  output  1  inflight or FIFO non-empty

Behaviour:
- Reset state (registered, applied on the rst edge): rr_ptr=0, inflight=0, inflight_id=0, FIFO empty (count=0, pointers 0), rsp_valid=0, busy=0.
- dp_data_in1, dp_data_in2 and dp_kernel_enable are combinational from the granted slice. When there is no grant they are driven to 0.
- Pop: pop = rsp_valid & rsp_ready.
- Issue condition: issue_ok = (count + inflight - pop) < 2. This guarantees a FIFO slot for every in-flight result.
- Grant: when issue_ok, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ. req_ready[grant]=1; all other bits are 0.
- When issue_ok=0, req_ready=0 for all requesters.
- Issue (handshake in cycle t) has these effects at the edge:
  - inflight<=1
  - inflight_id<=grant
  - rr_ptr<=(grant+1) mod NUM_REQ
- No issue in cycle t: inflight<=0; rr_ptr is unchanged.
- Result capture: if inflight=1 in cycle t+1, push {inflight_id, dp_result} into the FIFO at the end of t+1. Fixed latency, no tag on the datapath side.
- Throughput: with rsp_ready held high, one issue per cycle. Issue-to-rsp_valid latency is 2 cycles.
- Simultaneous push and pop in one cycle: count is unchanged, and FIFO order is preserved.
- Push when full cannot occur by construction. Verification asserts this.
- rsp_id, rsp_data: held stable while rsp_valid=1 and rsp_ready=0.
- Requesters may drop req_valid without a handshake. A request is not latched until ready=1.
- Reset mid-operation: the in-flight result is discarded, the FIFO is flushed, and rr_ptr returns to 0. The datapath result register resets on the same edge.
- Arithmetic is done by the datapath: result = (kernel ? ROM[a[3:0]] : 0) + ~b + a, mod 256. The arbiter passes bits through unchanged.

Optional Feature:
- Macro: EVAL_CLK_GATE_EN.
- Defined: dp_clk_en = issue | inflight, registered-free combinational. The datapath clock enable is high only in the issue cycle and the capture cycle, and it is low when idle, including during FIFO backpressure with no issue.
- Not defined: dp_clk_en is tied to 1.
- Functional results and timing are identical in both builds.

Test Plan:
- Single op, kernel: req0 a=0x00 b=0x00 kernel=1, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_id=0, rsp_data=56 (57+255+0).
- Kernel off: req1 a=0x00 b=0x00 kernel=0 -> rsp_id=1, rsp_data=255. Then a=0x03 b=0x10 kernel=1 -> rsp_data=84 (98+239+3 mod 256).
- Round-robin: NUM_REQ=2, both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 with one issue per cycle; response ids arrive in the same order.
- Backpressure: rsp_ready=0, req0 streaming -> exactly 2 issues, then req_ready=0. FIFO holds 2 entries stable. Raising rsp_ready resumes 1 issue/cycle with no loss and no duplication.
- Reset mid-op: assert rst the cycle after an issue -> no response emitted, rsp_valid=0, busy=0. The next grant goes to req0 if both are valid.
- With EVAL_CLK_GATE_EN: idle bench -> dp_clk_en=0. Single issue -> dp_clk_en high for exactly 2 cycles. Without the macro -> dp_clk_en constant 1.

Source files
------------

// File: rtl/eval_arbiter.sv
// eval_arbiter: round-robin front end sharing one eval datapath, with a 2-entry tagged response FIFO.
// Define EVAL_CLK_GATE_EN to limit dp_clk_en to issue and capture cycles.
module eval_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_kernel,
  output logic [7:0]           dp_data_in1,
  output logic [7:0]           dp_data_in2,
  output logic                 dp_kernel_enable,
  output logic                 dp_clk_en,
  input  logic [7:0]           dp_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 busy
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both high at the
  // rising edge; valid may drop without a transfer, and nothing is latched until ready=1.

  localparam int EW = ID_W + 8;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] inflight_id;
  logic [ID_W-1:0] grant;
  logic            inflight;
  logic            issue;
  logic            pop;
  logic            push;
  logic            issue_ok;
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [EW-1:0]   mem [2];
  logic [2:0]      occupancy;

  assign pop       = rsp_valid & rsp_ready;
  assign push      = inflight;
  // Reserve a FIFO slot for every in-flight result so capture can never overflow.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue_ok  = (occupancy < 3'd2);

  always_comb begin
    int idx;
    idx              = 0;
    issue            = 1'b0;
    grant            = '0;
    req_ready        = '0;
    dp_data_in1      = '0;
    dp_data_in2      = '0;
    dp_kernel_enable = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (issue_ok && !issue && req_valid[idx]) begin
        issue            = 1'b1;
        grant            = ID_W'(idx);
        req_ready[idx]   = 1'b1;
        dp_data_in1      = req_a[8*idx +: 8];
        dp_data_in2      = req_b[8*idx +: 8];
        dp_kernel_enable = req_kernel[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
      count       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_id <= grant;
        rr_ptr      <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
      end
      // Datapath result is valid exactly one cycle after issue; no tag travels with it.
      if (push) begin
        mem[wr_ptr] <= {inflight_id, dp_result};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rsp_valid          = (count != 2'd0);
  assign {rsp_id, rsp_data} = mem[rd_ptr];
  assign busy               = inflight | rsp_valid;

`ifdef EVAL_CLK_GATE_EN
  assign dp_clk_en = issue | inflight;
`else
  assign dp_clk_en = 1'b1;
`endif

endmodule

// File: tb/tb_eval_arbiter.sv
// Directed bench for eval_arbiter: vector table of single ops plus round-robin, backpressure
// and reset-mid-op sequences, with a behavioural stand-in for the eval datapath.
module tb_eval_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 2;
`ifdef EVAL_CLK_GATE_EN
  localparam logic GATE = 1'b1;
`else
  localparam logic GATE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ-1:0]   req_kernel;
  logic [7:0]           dp_data_in1;
  logic [7:0]           dp_data_in2;
  logic                 dp_kernel_enable;
  logic                 dp_clk_en;
  logic [7:0]           dp_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_data;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  logic [ID_W+7:0] exp_q[$];
  logic [7:0]      exp_for [NUM_REQ];
  logic [7:0]      rom [16];

  eval_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_kernel(req_kernel),
    .dp_data_in1(dp_data_in1), .dp_data_in2(dp_data_in2),
    .dp_kernel_enable(dp_kernel_enable), .dp_clk_en(dp_clk_en), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // datapath stand-in: registered ROM/invert/add kernel
  always_ff @(posedge clk) begin
    if (rst) dp_result <= 8'd0;
    else if (dp_clk_en)
      dp_result <= (dp_kernel_enable ? rom[dp_data_in1[3:0]] : 8'd0) + ~dp_data_in2 + dp_data_in1;
  end

  // a capture must always find a free FIFO slot
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (({1'b0, dut.count} + {2'b00, dut.inflight}) > 3'd2) begin
        errors++;
        $display("FAIL fifo_overflow: count=%0d inflight=%0d required count+inflight<=2",
                 dut.count, dut.inflight);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic clear_reqs();
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_kernel = '0;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic k);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_kernel[id]   = k;
  endtask

  task automatic do_reset();
    clear_reqs();
    rsp_ready = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // called at the negative edge: score responses, record accepted requests
  task automatic sb_cycle();
    logic [ID_W+7:0] e;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'({rsp_id, rsp_data}), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp", 32'({rsp_id, rsp_data}), 32'(e));
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i]) exp_q.push_back({ID_W'(i), exp_for[i]});
  endtask

  task automatic drain();
    bit done = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      sb_cycle();
      if (exp_q.size() == 0 && !rsp_valid && !busy) done = 1'b1;
      @(posedge clk); #1;
    end
    check("drain_done", 32'(done), 32'd1);
    check("drain_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       k;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * 13 + 5);
    rom[0] = 8'd57;
    rom[3] = 8'd98;

    vecs[0] = '{0, 8'h00, 8'h00, 1'b1, 8'd56};
    vecs[1] = '{1, 8'h00, 8'h00, 1'b0, 8'd255};
    vecs[2] = '{1, 8'h03, 8'h10, 1'b1, 8'd84};
    vecs[3] = '{0, 8'hFF, 8'hFF, 1'b0, 8'd255};
    vecs[4] = '{0, 8'h10, 8'h01, 1'b1, 8'd71};
    vecs[5] = '{1, 8'h80, 8'h7F, 1'b0, 8'd0};
    vecs[6] = '{0, 8'h13, 8'hFF, 1'b1, 8'd117};

    clear_reqs();
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_dp_in1", 32'(dp_data_in1), 32'd0);
    check("rst_dp_clk_en", 32'(dp_clk_en), 32'(!GATE));
    @(posedge clk); #1;

    // single-op vectors
    for (int v = 0; v < 7; v++) begin
      clear_reqs();
      rsp_ready = 1'b1;
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].k);
      req_valid[vecs[v].id] = 1'b1;
      @(negedge clk);
      check("vec_grant", 32'(req_ready), 32'(1 << vecs[v].id));
      check("vec_dp_in1", 32'(dp_data_in1), 32'(vecs[v].a));
      check("vec_dp_in2", 32'(dp_data_in2), 32'(vecs[v].b));
      check("vec_dp_kernel", 32'(dp_kernel_enable), 32'(vecs[v].k));
      check("vec_clk_en_issue", 32'(dp_clk_en), 32'd1);
      @(posedge clk); #1;
      clear_reqs();
      @(negedge clk);
      check("vec_inflight_rsp_valid", 32'(rsp_valid), 32'd0);
      check("vec_inflight_busy", 32'(busy), 32'd1);
      check("vec_nogrant_in1", 32'(dp_data_in1), 32'd0);
      check("vec_clk_en_capture", 32'(dp_clk_en), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      check("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].exp));
      check("vec_clk_en_idle", 32'(dp_clk_en), 32'(!GATE));
      @(posedge clk); #1;
      @(negedge clk);
      check("vec_popped", 32'(rsp_valid), 32'd0);
      check("vec_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    // round robin with both requesters streaming
    do_reset();
    set_req(0, 8'h00, 8'h00, 1'b1); exp_for[0] = 8'd56;
    set_req(1, 8'h03, 8'h10, 1'b1); exp_for[1] = 8'd84;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      sb_cycle();
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // backpressure: two issues, then stall with a stable FIFO head
    do_reset();
    set_req(0, 8'h03, 8'h10, 1'b1); exp_for[0] = 8'd84;
    req_valid = 2'b01;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), (c < 2) ? 32'd1 : 32'd0);
      if (c >= 3) begin
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check("bp_hold_id", 32'(rsp_id), 32'd0);
        check("bp_hold_data", 32'(rsp_data), 32'd84);
        check("bp_clk_en_stall", 32'(dp_clk_en), 32'(!GATE));
      end
      sb_cycle();
      @(posedge clk); #1;
      if (c == 0) begin
        set_req(0, 8'h00, 8'h00, 1'b1);
        exp_for[0] = 8'd56;
      end
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_resume_ready", 32'(req_ready), 32'd1);
      sb_cycle();
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // reset the cycle after an issue
    do_reset();
    set_req(0, 8'h00, 8'h00, 1'b1);
    set_req(1, 8'h03, 8'h10, 1'b1);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rm_issue", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("rm_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    check("rm_no_late_rsp", 32'(rsp_valid), 32'd0);
    check("rm_grant_req0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
